hamming_secded_decoder: RTL



---
 rtl/hamming_secded_decoder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder: two-stage pipelined Hamming SEC/SECDED decoder with valid/ready flow control
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in_codeword on the receive side;
// out_valid/out_ready/out_data/out_sindrome/out_err_corr/out_err_uncorr on the consumer side;
// clr_cnt clears cnt_corr/cnt_uncorr, saturating counts of corrected/uncorrectable handshaked words.
module hamming_secded_decoder #(
    parameter  int DATA_W = 4,
    parameter  int SECDED = 0,
    parameter  int CNT_W  = 16,
    localparam int PAR_W  = $clog2(DATA_W + $clog2(DATA_W + 1) + 1),
    localparam int N      = DATA_W + PAR_W,
    localparam int CW_W   = N + (SECDED != 0 ? 1 : 0)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   in_codeword,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PAR_W-1:0]  out_sindrome,
    output logic              out_err_corr,
    output logic              out_err_uncorr,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_uncorr
);
    localparam logic [PAR_W-1:0] N_S = PAR_W'(N);

    // Hamming position (1-based) of data bit i: the i-th non-power-of-two position
    function automatic int data_pos(int i);
        int pos = 0;
        int cnt = 0;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == i) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    logic [PAR_W-1:0]  syn;
    logic              par;
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] fixed;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [PAR_W-1:0]  s1_syn;
    logic              s1_par;
    logic              s2_valid;
    logic              s2_adv;
    logic              flip;
    logic              corr;
    logic              uncorr;
    logic              hs;

    always_comb begin
        syn = '0;
        for (int k = 0; k < N; k++)
            for (int j = 0; j < PAR_W; j++)
                if (((k + 1) & (1 << j)) != 0) syn[j] = syn[j] ^ in_codeword[k];
    end

    assign par = (SECDED != 0) && (^in_codeword);

    // Only the data bits are kept past stage 1; parity-position errors never alter data
    for (genvar i = 0; i < DATA_W; i++) begin : g_d
        localparam int P = data_pos(i);
        localparam logic [PAR_W-1:0] SP = PAR_W'(P);
        assign raw[i]   = in_codeword[P-1];
        assign fixed[i] = s1_data[i] ^ (flip && s1_syn == SP);
    end

    // Without SECDED any in-range syndrome is a single error; with SECDED it also needs odd parity
    assign flip   = s1_syn != '0 && s1_syn <= N_S && (SECDED == 0 || s1_par);
    assign corr   = flip || (SECDED != 0 && s1_syn == '0 && s1_par);
    assign uncorr = s1_syn != '0 && !flip;

    assign s2_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_adv;
    assign out_valid = s2_valid;
    assign hs        = s2_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid       <= 1'b0;
            s1_data        <= '0;
            s1_syn         <= '0;
            s1_par         <= 1'b0;
            s2_valid       <= 1'b0;
            out_data       <= '0;
            out_sindrome   <= '0;
            out_err_corr   <= 1'b0;
            out_err_uncorr <= 1'b0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (in_ready && in_valid) begin
                s1_data <= raw;
                s1_syn  <= syn;
                s1_par  <= par;
            end
            if (s2_adv) s2_valid <= s1_valid;
            if (s2_adv && s1_valid) begin
                out_data       <= fixed;
                out_sindrome   <= s1_syn;
                out_err_corr   <= corr;
                out_err_uncorr <= uncorr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (clr_cnt) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else begin
            if (hs && out_err_corr && cnt_corr != '1) cnt_corr <= cnt_corr + CNT_W'(1);
            if (hs && out_err_uncorr && cnt_uncorr != '1) cnt_uncorr <= cnt_uncorr + CNT_W'(1);
        end
    end
endmodule
